// File: rtl/banked_scratchpad_v2.sv
// banked_scratchpad_v2
// Dual-port banked byte scratchpad. Port A is a wide, length-masked interface
// port. Port B is a narrow, byte-enabled system-bus port. Each bank is one
// byte lane holding 2**A_WID rows. The two ports are arbitrated per
// (bank, row), and the interface side wins a conflict. A hardware clear engine
// zero-fills every row through port A.
//
// Handshake semantics:
//   Interface: an access is accepted in any cycle where if_en && if_ready.
//              if_ready is low while the clear engine is busy. The master holds
//              its request until it is accepted.
//   System bus: the access happens in any cycle where sb_req && sb_gnt. sb_gnt
//              is combinational. It is low while the clear engine is busy, and
//              also on a same-location conflict with an accepted interface
//              access in which at least one side writes. The master holds its
//              request until it is granted.
//   Reads on either port return data exactly one cycle later. In that cycle
//   *_rvalid is high for one cycle, and *_rdata holds its value until the next
//   read on the same port.
module banked_scratchpad_v2 #(
   parameter int NUM_BANKS = 16,
   parameter int A_WID     = 4,
   parameter int D_WID     = 8,
   parameter int SB_LANES  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr_start,
   output logic                          clr_busy,
   output logic                          clr_done,
   input  logic                          if_en,
   input  logic                          if_we,
   input  logic [$clog2(NUM_BANKS):0]    if_len,
   input  logic [31:0]                   if_addr,
   input  logic [NUM_BANKS*D_WID-1:0]    if_wdata,
   output logic                          if_ready,
   output logic [NUM_BANKS*D_WID-1:0]    if_rdata,
   output logic                          if_rvalid,
   input  logic                          sb_req,
   input  logic                          sb_we,
   input  logic [SB_LANES-1:0]           sb_be,
   input  logic [31:0]                   sb_addr,
   input  logic [SB_LANES*D_WID-1:0]     sb_wdata,
   output logic                          sb_gnt,
   output logic [SB_LANES*D_WID-1:0]     sb_rdata,
   output logic                          sb_rvalid
);

   localparam int OFF_W = $clog2(NUM_BANKS);
   localparam int DEPTH = 1 << A_WID;
   localparam int LW    = NUM_BANKS * D_WID;
   localparam int SW    = SB_LANES * D_WID;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Clear engine state
   logic [1:0]       state_q, state_d;
   logic [A_WID-1:0] cnt_q, cnt_d;
   logic             busy;
   logic             clearing;

   // Port A decode
   logic [OFF_W-1:0]                a_off;
   logic [A_WID-1:0]                a_row_base;
   logic [NUM_BANKS-1:0]            a_act;
   logic [NUM_BANKS-1:0][A_WID-1:0] a_row;
   logic [NUM_BANKS-1:0][D_WID-1:0] a_wd;
   logic [LW-1:0]                   a_shift;
   int                              a_lane;

   // Port B decode
   logic [OFF_W-1:0]                b_off;
   logic [A_WID-1:0]                b_row_base;
   logic [NUM_BANKS-1:0]            b_win;
   logic [NUM_BANKS-1:0]            b_act;
   logic [NUM_BANKS-1:0][A_WID-1:0] b_row;
   logic [NUM_BANKS-1:0][D_WID-1:0] b_wd;
   logic [SW-1:0]                   b_shift;
   logic [SB_LANES-1:0]             be_shift;
   int                              b_lane;

   // Arbitration and bank controls
   logic                            if_acc;
   logic                            if_rd_acc;
   logic                            sb_rd_acc;
   logic                            conflict;
   logic [NUM_BANKS-1:0]            ram_a_we;
   logic [NUM_BANKS-1:0][A_WID-1:0] ram_a_row;
   logic [NUM_BANKS-1:0][D_WID-1:0] ram_a_wd;
   logic [NUM_BANKS-1:0]            ram_b_we;

   // Read-side registers
   logic                 if_rvalid_q, if_rvalid_d;
   logic [OFF_W-1:0]     if_off_q, if_off_d;
   logic [NUM_BANKS-1:0] if_mask_q, if_mask_d;
   logic                 sb_rvalid_q, sb_rvalid_d;
   logic [OFF_W-1:0]     sb_off_q, sb_off_d;
   logic                 sb_seen_q, sb_seen_d;
   logic [LW-1:0]        a_rd_all;
   logic [LW-1:0]        b_rd_all;
   logic [LW-1:0]        a_pick;
   logic [LW-1:0]        b_pick;

   // Address bits above the array are ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:OFF_W+A_WID], sb_addr[31:OFF_W+A_WID]};

   // Next state for the clear engine: IDLE -> CLEAR (one row per cycle) -> DONE -> IDLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_start) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == A_WID'(DEPTH - 1)) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + A_WID'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Clear engine state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign clearing = (state_q == ST_CLEAR);
   assign clr_busy = busy;
   assign clr_done = (state_q == ST_DONE);

   // Port A: map lanes to banks, rotated by the byte offset. Banks below the
   // offset belong to the next row.
   always_comb begin
      a_off      = if_addr[OFF_W-1:0];
      a_row_base = if_addr[OFF_W +: A_WID];
      a_act      = '0;
      a_row      = '0;
      a_wd       = '0;
      a_shift    = '0;
      a_lane     = 0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         a_lane   = (b - int'(a_off)) & (NUM_BANKS - 1);
         a_act[b] = (a_lane < int'(if_len));
         a_row[b] = (b < int'(a_off)) ? a_row_base + A_WID'(1) : a_row_base;
         a_shift  = if_wdata >> (a_lane * D_WID);
         a_wd[b]  = a_shift[D_WID-1:0];
      end
   end

   // Port B: same rotation over a SB_LANES-wide window. Write lanes are
   // qualified by the byte enables.
   always_comb begin
      b_off      = sb_addr[OFF_W-1:0];
      b_row_base = sb_addr[OFF_W +: A_WID];
      b_win      = '0;
      b_act      = '0;
      b_row      = '0;
      b_wd       = '0;
      b_shift    = '0;
      be_shift   = '0;
      b_lane     = 0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         b_lane   = (b - int'(b_off)) & (NUM_BANKS - 1);
         b_win[b] = (b_lane < SB_LANES);
         be_shift = sb_be >> b_lane;
         b_act[b] = b_win[b] && be_shift[0];
         b_row[b] = (b < int'(b_off)) ? b_row_base + A_WID'(1) : b_row_base;
         b_shift  = sb_wdata >> (b_lane * D_WID);
         b_wd[b]  = b_shift[D_WID-1:0];
      end
   end

   // Acceptance and same-location arbitration; the interface always wins.
   // A system-bus read touches its whole window, whatever the byte enables.
   always_comb begin
      if_ready  = !busy && !rst;
      if_acc    = if_en && if_ready;
      if_rd_acc = if_acc && !if_we;
      conflict  = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (if_acc && a_act[b] && sb_req && (sb_we ? b_act[b] : b_win[b]) &&
             (a_row[b] == b_row[b]) && (if_we || sb_we)) begin
            conflict = 1'b1;
         end
      end
      sb_gnt    = sb_req && !busy && !rst && !conflict;
      sb_rd_acc = sb_gnt && !sb_we;
   end

   // Bank port controls; the clear engine owns port A while it runs.
   always_comb begin
      ram_a_we  = '0;
      ram_a_row = '0;
      ram_a_wd  = '0;
      ram_b_we  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (clearing) begin
            ram_a_we[b]  = 1'b1;
            ram_a_row[b] = cnt_q;
            ram_a_wd[b]  = '0;
         end else begin
            ram_a_we[b]  = if_acc && if_we && a_act[b];
            ram_a_row[b] = a_row[b];
            ram_a_wd[b]  = a_wd[b];
         end
         ram_b_we[b] = sb_gnt && sb_we && b_act[b];
      end
   end

   // Per-bank true dual-port RAM with read-first registered outputs
   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic [D_WID-1:0] mem [DEPTH];
      logic [D_WID-1:0] a_rd_q;
      logic [D_WID-1:0] b_rd_q;

      // Both ports write and read this bank's array
      always_ff @(posedge clk) begin
         if (ram_a_we[g]) mem[ram_a_row[g]] <= ram_a_wd[g];
         if (ram_b_we[g]) mem[b_row[g]] <= b_wd[g];
         if (if_rd_acc) a_rd_q <= mem[ram_a_row[g]];
         if (sb_rd_acc) b_rd_q <= mem[b_row[g]];
      end

      assign a_rd_all[g*D_WID +: D_WID] = a_rd_q;
      assign b_rd_all[g*D_WID +: D_WID] = b_rd_q;
   end

   // Capture the offset and lane mask with each accepted read
   always_comb begin
      if_rvalid_d = if_rd_acc;
      if_off_d    = if_off_q;
      if_mask_d   = if_mask_q;
      if (if_rd_acc) begin
         if_off_d = a_off;
         for (int k = 0; k < NUM_BANKS; k++) begin
            if_mask_d[k] = (k < int'(if_len));
         end
      end
      sb_rvalid_d = sb_rd_acc;
      sb_off_d    = sb_rd_acc ? b_off : sb_off_q;
      sb_seen_d   = sb_seen_q || sb_rd_acc;
   end

   // Read-side pipeline registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_rvalid_q <= 1'b0;
         if_off_q    <= '0;
         if_mask_q   <= '0;
         sb_rvalid_q <= 1'b0;
         sb_off_q    <= '0;
         sb_seen_q   <= 1'b0;
      end else begin
         if_rvalid_q <= if_rvalid_d;
         if_off_q    <= if_off_d;
         if_mask_q   <= if_mask_d;
         sb_rvalid_q <= sb_rvalid_d;
         sb_off_q    <= sb_off_d;
         sb_seen_q   <= sb_seen_d;
      end
   end

   // Rotate bank read data back into lane order and mask inactive lanes
   always_comb begin
      if_rdata = '0;
      sb_rdata = '0;
      a_pick   = '0;
      b_pick   = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         a_pick = a_rd_all >> (((int'(if_off_q) + k) & (NUM_BANKS - 1)) * D_WID);
         if (if_mask_q[k]) if_rdata[k*D_WID +: D_WID] = a_pick[D_WID-1:0];
      end
      for (int k = 0; k < SB_LANES; k++) begin
         b_pick = b_rd_all >> (((int'(sb_off_q) + k) & (NUM_BANKS - 1)) * D_WID);
         if (sb_seen_q) sb_rdata[k*D_WID +: D_WID] = b_pick[D_WID-1:0];
      end
   end

   assign if_rvalid = if_rvalid_q;
   assign sb_rvalid = sb_rvalid_q;

endmodule

// File: tb/tb_banked_scratchpad_v2.sv
// Directed and random stimulus for banked_scratchpad_v2, checked against a
// flat 256-byte reference model. Lane k of an access at address a is byte
// (a + k) mod 256.
module tb_banked_scratchpad_v2;

   localparam int NB  = 16;
   localparam int DW  = 8;
   localparam int SBL = 4;
   localparam int LW  = NB * DW;
   localparam int SW  = SBL * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr_start = 1'b0;
   logic          clr_busy, clr_done;
   logic          if_en = 1'b0, if_we = 1'b0;
   logic [4:0]    if_len = '0;
   logic [31:0]   if_addr = '0;
   logic [LW-1:0] if_wdata = '0;
   logic          if_ready;
   logic [LW-1:0] if_rdata;
   logic          if_rvalid;
   logic          sb_req = 1'b0, sb_we = 1'b0;
   logic [3:0]    sb_be = '0;
   logic [31:0]   sb_addr = '0;
   logic [SW-1:0] sb_wdata = '0;
   logic          sb_gnt;
   logic [SW-1:0] sb_rdata;
   logic          sb_rvalid;

   logic [7:0]    ref_mem [256];
   logic [LW-1:0] exp_if_q [$];
   logic [SW-1:0] exp_sb_q [$];
   logic [LW-1:0] last_if;
   int            n_checks = 0;
   int            n_pass = 0;

   // Clock
   always #5 clk = ~clk;

   banked_scratchpad_v2 dut (
      .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
      .if_en(if_en), .if_we(if_we), .if_len(if_len), .if_addr(if_addr), .if_wdata(if_wdata),
      .if_ready(if_ready), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
      .sb_req(sb_req), .sb_we(sb_we), .sb_be(sb_be), .sb_addr(sb_addr), .sb_wdata(sb_wdata),
      .sb_gnt(sb_gnt), .sb_rdata(sb_rdata), .sb_rvalid(sb_rvalid)
   );

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
   endtask

   task automatic checkw(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
   endtask

   task automatic checks(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      if_en = 1'b0; if_we = 1'b0; if_len = '0; if_addr = '0; if_wdata = '0;
      sb_req = 1'b0; sb_we = 1'b0; sb_be = '0; sb_addr = '0; sb_wdata = '0;
   endtask

   function automatic int bidx(input logic [31:0] a, input int k);
      logic [31:0] s;
      s = a + 32'(k);
      return int'(s[7:0]);
   endfunction

   // One clock cycle with both ports driven: checks the grant, queues read
   // expectations, updates the model, then checks the rvalid/rdata that follow.
   task automatic do_cycle(input logic ie, input logic iw, input logic [4:0] ilen,
                           input logic [31:0] iaddr, input logic [LW-1:0] iwd,
                           input logic sr, input logic sw, input logic [3:0] sbe,
                           input logic [31:0] saddr, input logic [SW-1:0] swd,
                           input string tag);
      logic          cfl, egnt, ird, srd;
      logic [LW-1:0] erd;
      logic [SW-1:0] esd;
      logic [LW-1:0] got_if;
      logic [SW-1:0] got_sb;
      if_en = ie; if_we = iw; if_len = ilen; if_addr = iaddr; if_wdata = iwd;
      sb_req = sr; sb_we = sw; sb_be = sbe; sb_addr = saddr; sb_wdata = swd;
      #1;
      cfl = 1'b0;
      if (ie && sr && (iw || sw)) begin
         for (int k = 0; k < int'(ilen) && k < NB; k++) begin
            for (int j = 0; j < SBL; j++) begin
               if (bidx(iaddr, k) == bidx(saddr, j) && (!sw || sbe[j])) cfl = 1'b1;
            end
         end
      end
      egnt = sr && !cfl;
      check1({tag, " sb_gnt"}, sb_gnt, egnt);
      ird = ie && !iw;
      srd = egnt && !sw;
      if (ird) begin
         erd = '0;
         for (int k = 0; k < int'(ilen) && k < NB; k++) erd[k*DW +: DW] = ref_mem[bidx(iaddr, k)];
         exp_if_q.push_back(erd);
      end
      if (srd) begin
         esd = '0;
         for (int j = 0; j < SBL; j++) esd[j*DW +: DW] = ref_mem[bidx(saddr, j)];
         exp_sb_q.push_back(esd);
      end
      if (ie && iw) begin
         for (int k = 0; k < int'(ilen) && k < NB; k++) ref_mem[bidx(iaddr, k)] = iwd[k*DW +: DW];
      end
      if (egnt && sw) begin
         for (int j = 0; j < SBL; j++) begin
            if (sbe[j]) ref_mem[bidx(saddr, j)] = swd[j*DW +: DW];
         end
      end
      @(posedge clk);
      #1;
      idle_inputs();
      check1({tag, " if_rvalid"}, if_rvalid, ird);
      check1({tag, " sb_rvalid"}, sb_rvalid, srd);
      if (ird && exp_if_q.size() > 0) begin
         got_if  = if_rdata;
         last_if = exp_if_q.pop_front();
         checkw({tag, " if_rdata"}, got_if, last_if);
      end
      if (srd && exp_sb_q.size() > 0) begin
         got_sb = sb_rdata;
         checks({tag, " sb_rdata"}, got_sb, exp_sb_q.pop_front());
      end
   endtask

   task automatic if_wr(input logic [4:0] len, input logic [31:0] addr, input logic [LW-1:0] d, input string tag);
      do_cycle(1'b1, 1'b1, len, addr, d, 1'b0, 1'b0, 4'h0, 32'h0, '0, tag);
   endtask

   task automatic if_rd(input logic [4:0] len, input logic [31:0] addr, input string tag);
      do_cycle(1'b1, 1'b0, len, addr, '0, 1'b0, 1'b0, 4'h0, 32'h0, '0, tag);
   endtask

   task automatic sb_op(input logic w, input logic [3:0] be, input logic [31:0] addr, input logic [SW-1:0] d, input string tag);
      do_cycle(1'b0, 1'b0, 5'd0, 32'h0, '0, 1'b1, w, be, addr, d, tag);
   endtask

   task automatic fill(input logic [7:0] v, input logic rnd);
      for (int r = 0; r < 16; r++) begin
         if (rnd) if_wr(5'd16, 32'(r * 16), {$urandom(), $urandom(), $urandom(), $urandom()}, "fill");
         else     if_wr(5'd16, 32'(r * 16), {16{v}}, "fill");
      end
   endtask

   task automatic read_all_rows(input string tag);
      for (int r = 0; r < 16; r++) if_rd(5'd16, 32'(r * 16), tag);
   endtask

   task automatic start_clear();
      clr_start = 1'b1;
      @(posedge clk);
      #1;
      clr_start = 1'b0;
   endtask

   // Directed sequence
   initial begin
      logic [LW-1:0] d;
      logic [31:0]   r32;
      logic [7:0]    base;

      // Reset state
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check1("rst clr_busy", clr_busy, 1'b0);
      check1("rst clr_done", clr_done, 1'b0);
      check1("rst if_rvalid", if_rvalid, 1'b0);
      check1("rst sb_rvalid", sb_rvalid, 1'b0);
      check1("rst if_ready", if_ready, 1'b0);
      check1("rst sb_gnt", sb_gnt, 1'b0);
      checkw("rst if_rdata", if_rdata, '0);
      checks("rst sb_rdata", sb_rdata, '0);
      rst = 1'b0;
      #1;
      check1("post rst if_ready", if_ready, 1'b1);

      // Give every byte a known value
      fill(8'h00, 1'b1);

      // Aligned full write then read
      for (int k = 0; k < NB; k++) d[k*DW +: DW] = 8'(k + 1);
      if_wr(5'd16, 32'h20, d, "aligned wr");
      if_rd(5'd16, 32'h20, "aligned rd");
      checkw("aligned value", last_if, d);
      do_cycle(1'b0, 1'b0, 5'd0, 32'h0, '0, 1'b0, 1'b0, 4'h0, 32'h0, '0, "idle");
      checkw("rdata hold", if_rdata, d);

      // Unaligned, length-masked write that wraps from row 15 into row 0
      d = '0;
      for (int k = 0; k < 5; k++) d[k*DW +: DW] = 8'(8'hA0 + k);
      if_wr(5'd5, 32'hFD, d, "wrap wr");
      if_rd(5'd5, 32'hFD, "wrap rd");
      checkw("wrap value", last_if, d);
      if_rd(5'd16, 32'hF0, "row15 rd");
      if_rd(5'd16, 32'h100, "row0 rd");

      // Zero length: write is a no-op, read returns valid zeros
      if_wr(5'd0, 32'h33, {16{8'h5A}}, "len0 wr");
      if_rd(5'd0, 32'h33, "len0 rd");
      if_rd(5'd16, 32'h30, "len0 check");

      // System-bus byte enables
      sb_op(1'b1, 4'b0101, 32'h0E, 32'h44332211, "sb be wr");
      sb_op(1'b0, 4'b1111, 32'h0E, '0, "sb rd");
      if_rd(5'd4, 32'h0E, "sb cross");
      sb_op(1'b0, 4'b0000, 32'h3FE, '0, "sb rd no be");

      // Interface write wins over an overlapping system-bus read
      for (int k = 0; k < 4; k++) d[k*DW +: DW] = 8'(8'hD0 + k);
      do_cycle(1'b1, 1'b1, 5'd4, 32'h40, d, 1'b1, 1'b0, 4'hF, 32'h42, '0, "conflict");
      sb_op(1'b0, 4'hF, 32'h42, '0, "after conflict");

      // Read/read to the same location is granted on both ports
      do_cycle(1'b1, 1'b0, 5'd4, 32'h40, '0, 1'b1, 1'b0, 4'hF, 32'h40, '0, "rd rd");

      // System-bus write against an interface read of the same byte
      do_cycle(1'b1, 1'b0, 5'd16, 32'h60, '0, 1'b1, 1'b1, 4'h1, 32'h6F, 32'hEE, "sbw ifr");
      // Adjacent but disjoint writes on both ports
      do_cycle(1'b1, 1'b1, 5'd2, 32'h70, {16{8'h77}}, 1'b1, 1'b1, 4'b0011, 32'h6E, 32'h9988_6655, "adjacent");
      // Disabled sb lane overlapping an interface write is not a conflict
      do_cycle(1'b1, 1'b1, 5'd2, 32'h80, {16{8'h12}}, 1'b1, 1'b1, 4'b1100, 32'h80, 32'hCCBB_AA99, "be masked");
      if_rd(5'd16, 32'h60, "disjoint chk");
      if_rd(5'd16, 32'h80, "masked chk");

      // Random concurrent traffic on a shared neighbourhood
      for (int i = 0; i < 40; i++) begin
         r32  = $urandom();
         base = 8'($urandom_range(0, 255));
         do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 16)),
                  {r32[31:8], base}, {$urandom(), $urandom(), $urandom(), $urandom()},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  32'(base) + 32'($urandom_range(0, 18)), $urandom(), "rand");
      end

      // Full hardware clear with both masters holding requests
      fill(8'hFF, 1'b0);
      start_clear();
      if_en = 1'b1; if_we = 1'b0; if_len = 5'd16; if_addr = 32'h0;
      sb_req = 1'b1; sb_we = 1'b0; sb_be = 4'hF; sb_addr = 32'h0;
      for (int i = 1; i <= 17; i++) begin
         #1;
         check1("clr busy", clr_busy, 1'b1);
         check1("clr done", clr_done, (i == 17));
         check1("clr if_ready", if_ready, 1'b0);
         check1("clr sb_gnt", sb_gnt, 1'b0);
         if (i == 17) idle_inputs();
         @(posedge clk);
         #1;
         check1("clr if_rvalid", if_rvalid, 1'b0);
         check1("clr sb_rvalid", sb_rvalid, 1'b0);
      end
      check1("clr end busy", clr_busy, 1'b0);
      check1("clr end done", clr_done, 1'b0);
      for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
      read_all_rows("after clr");
      sb_op(1'b0, 4'hF, 32'hFE, '0, "after clr sb");

      // clr_start while busy is ignored: a single clear still takes 17 cycles
      start_clear();
      clr_start = 1'b1;
      repeat (16) @(posedge clk);
      #1;
      clr_start = 1'b0;
      check1("restart done", clr_done, 1'b1);
      @(posedge clk);
      #1;
      check1("restart idle", clr_busy, 1'b0);

      // Reset in cycle 5 of a clear aborts it
      fill(8'hFF, 1'b0);
      if_rd(5'd16, 32'h50, "pre abort rd");
      sb_op(1'b0, 4'hF, 32'h50, '0, "pre abort sb");
      start_clear();
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check1("abort busy", clr_busy, 1'b0);
      check1("abort done", clr_done, 1'b0);
      checkw("abort if_rdata", if_rdata, '0);
      checks("abort sb_rdata", sb_rdata, '0);
      // A read presented while reset is high must not produce rvalid
      if_en = 1'b1; if_we = 1'b0; if_len = 5'd16; if_addr = 32'h0;
      @(posedge clk);
      #1;
      check1("abort no done", clr_done, 1'b0);
      check1("pending rvalid", if_rvalid, 1'b0);
      idle_inputs();
      rst = 1'b0;
      #1;
      for (int a = 0; a < 64; a++) ref_mem[a] = 8'h00;
      read_all_rows("after abort");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
